// File: rtl/cordic_gain_comp.sv
// Magnitude gain compensation for the CORDIC vectoring core: bit-serial multiply by 1/K.
// Build option: define CGC_ROUND_EN to round half toward +inf; undefined truncates toward -inf.
module cordic_gain_comp #(
    parameter int N    = 31,
    parameter int M    = 31,
    parameter int FRAC = 20,
    parameter int KINV = 636751
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N:0]   x_in,
    input  logic [M:0]   angle_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N:0]   mag_out,
    output logic [M:0]   angle_out,
    output logic         busy
);

    localparam int AW = N + 1 + FRAC + 1;
    localparam int CW = $clog2(FRAC + 1);
    localparam logic [FRAC-1:0] KINV_BITS = FRAC'(KINV);
`ifdef CGC_ROUND_EN
    localparam logic signed [AW-1:0] RND = AW'(1) << (FRAC - 1);
`else
    localparam logic signed [AW-1:0] RND = '0;
`endif

    typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

    state_t                 state;
    logic [CW-1:0]          cnt;
    logic signed [AW-1:0]   acc;
    logic signed [AW-1:0]   x_lat;
    logic [M:0]             angle_lat;
    logic signed [AW-1:0]   acc_rounded;
    logic signed [AW-1:0]   acc_shifted;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);

    assign acc_rounded = acc + RND;
    assign acc_shifted = acc_rounded >>> FRAC;

    // Bits 0..FRAC-1 are accumulated on cnt = 0..FRAC-1; the extra edge at
    // cnt == FRAC registers the rounded, rescaled product into the outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            acc       <= '0;
            x_lat     <= '0;
            angle_lat <= '0;
            mag_out   <= '0;
            angle_out <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        x_lat     <= AW'(signed'(x_in));
                        angle_lat <= angle_in;
                        acc       <= '0;
                        cnt       <= '0;
                        state     <= MUL;
                    end
                end
                MUL: begin
                    if (cnt == CW'(FRAC)) begin
                        mag_out   <= acc_shifted[N:0];
                        angle_out <= angle_lat;
                        state     <= DONE;
                    end else begin
                        if (KINV_BITS[cnt]) begin
                            acc <= acc + (x_lat <<< cnt);
                        end
                        cnt <= cnt + CW'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cordic_gain_comp.sv
// Self-checking bench for cordic_gain_comp: directed steps, queue scoreboard, assertion checks.
// Honours CGC_ROUND_EN in its reference model.
module tb_cordic_gain_comp;

    localparam int  FRAC = 20;
    localparam longint KINV = 636751;
`ifdef CGC_ROUND_EN
    localparam longint RND = longint'(1) << (FRAC - 1);
`else
    localparam longint RND = 0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] x_in;
    logic [31:0] angle_in;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] mag_out;
    logic [31:0] angle_out;
    logic        busy;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    int accept_cyc;
    logic [63:0] exp_q[$];

    cordic_gain_comp dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x_in      (x_in),
        .angle_in  (angle_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .mag_out   (mag_out),
        .angle_out (angle_out),
        .busy      (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // Reference: exact wide product, optional rounding, arithmetic rescale.
    function automatic logic [31:0] model(input logic [31:0] x);
        longint p;
        p = longint'(signed'(x)) * KINV + RND;
        p = p >>> FRAC;
        return p[31:0];
    endfunction

    task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic apply_stimulus(input logic [31:0] x, input logic [31:0] a);
        int guard = 0;
        @(negedge clk);
        x_in = x;
        angle_in = a;
        in_valid = 1'b1;
        while (!in_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        check_output("accept_ready", 64'(in_ready), 64'd1);
        accept_cyc = cyc + 1;
        exp_q.push_back({model(x), a});
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic receive(input bit chk_lat);
        int guard = 0;
        logic [63:0] e;
        out_ready = 1'b1;
        while (!out_valid && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        check_output("out_valid_seen", 64'(out_valid), 64'd1);
        if (chk_lat) check_output("latency", 64'(cyc - accept_cyc), 64'd21);
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 64'hDEAD_DEAD_DEAD_DEAD;
        check_output("mag_out", 64'(mag_out), 64'(e[63:32]));
        check_output("angle_out", 64'(angle_out), 64'(e[31:0]));
        @(negedge clk);
        check_output("pulse_one_cycle", 64'(out_valid), 64'd0);
        check_output("ready_after_done", 64'(in_ready), 64'd1);
    endtask

    initial begin
        logic [31:0] hold_mag;
        logic [31:0] hold_ang;
        int pulses;
        int guard;

        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        x_in = '0;
        angle_in = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check_output("rst_mag", 64'(mag_out), 64'd0);
        check_output("rst_angle", 64'(angle_out), 64'd0);
        check_output("rst_out_valid", 64'(out_valid), 64'd0);
        check_output("rst_in_ready", 64'(in_ready), 64'd1);
        check_output("rst_busy", 64'(busy), 64'd0);

        apply_stimulus(32'h0010_0000, 32'h1234_5678);
        check_output("busy_in_mul", 64'(busy), 64'd1);
        receive(1'b1);
        check_output("const_1p0", 64'(model(32'h0010_0000)), 64'h0009B74F);

        apply_stimulus(32'h00A0_0000, 32'hCAFE_0001);
        receive(1'b1);
        apply_stimulus(32'hFFF0_0000, 32'h8000_0000);
        receive(1'b1);
        apply_stimulus(32'h0000_0001, 32'h0000_0011);
        receive(1'b1);
        apply_stimulus(32'h0000_0000, 32'h0000_0022);
        receive(1'b1);
        apply_stimulus(32'h8000_0000, 32'hFFFF_FFFF);
        receive(1'b1);

        // Backpressure: sample B must wait while A's result is stalled.
        out_ready = 1'b0;
        apply_stimulus(32'h0035_4321, 32'hAAAA_5555);
        guard = 0;
        while (!out_valid && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        check_output("bp_out_valid", 64'(out_valid), 64'd1);
        hold_mag = mag_out;
        hold_ang = angle_out;
        x_in = 32'hFF12_3456;
        angle_in = 32'h0BAD_F00D;
        in_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check_output("bp_mag_stable", 64'(mag_out), 64'(hold_mag));
            check_output("bp_ang_stable", 64'(angle_out), 64'(hold_ang));
            check_output("bp_in_ready", 64'(in_ready), 64'd0);
            check_output("bp_valid_held", 64'(out_valid), 64'd1);
        end
        check_output("bp_first_mag", 64'(mag_out), 64'(model(32'h0035_4321)));
        check_output("bp_first_ang", 64'(angle_out), 64'hAAAA_5555);
        void'(exp_q.pop_front());
        out_ready = 1'b1;
        @(negedge clk);
        check_output("bp_released", 64'(out_valid), 64'd0);
        check_output("bp_ready_rise", 64'(in_ready), 64'd1);
        accept_cyc = cyc + 1;
        exp_q.push_back({model(32'hFF12_3456), 32'h0BAD_F00D});
        @(negedge clk);
        in_valid = 1'b0;
        check_output("bp_second_accepted", 64'(busy), 64'd1);
        receive(1'b1);

        // Reset while cnt == 10 in MUL; the pending result must vanish.
        apply_stimulus(32'h0020_0000, 32'h5555_AAAA);
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        check_output("mid_rst_ready", 64'(in_ready), 64'd1);
        check_output("mid_rst_busy", 64'(busy), 64'd0);
        check_output("mid_rst_valid", 64'(out_valid), 64'd0);
        check_output("mid_rst_mag", 64'(mag_out), 64'd0);
        check_output("mid_rst_angle", 64'(angle_out), 64'd0);
        pulses = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (out_valid) pulses++;
        end
        check_output("mid_rst_no_pulse", 64'(pulses), 64'd0);
        apply_stimulus(32'h0003_0000, 32'h7777_0000);
        receive(1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
